// File: rtl/rv32i_insn_encoder.sv
// rv32i_insn_encoder: packs RV32I fields into a 32-bit instruction word behind a 2-entry FIFO
// Ports: clock/rst_n; in_* request with valid/ready; out_* FIFO head with valid/ready;
// count_ok/count_bad saturating counts of legal/illegal accepted requests.
module rv32i_insn_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_op,
    input  logic [2:0]         in_f3,
    input  logic               in_alt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_insn,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] count_ok,
    output logic [COUNT_W-1:0] count_bad
);
    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_MISCMEM = 5'b00011;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_OP      = 5'b01100;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;
    localparam logic [2:0] F3_SLI     = 3'b001;
    localparam logic [2:0] F3_SRI     = 3'b101;

    logic [6:0]  opc;
    logic        shift;
    logic [31:0] enc;
    logic        bad;
    logic [32:0] mem [2];
    logic        head, tail;
    logic [1:0]  cnt;
    logic        push, pop;

    assign opc   = {in_op, 2'b11};
    assign shift = in_op == OP_OPIMM && (in_f3 == F3_SLI || in_f3 == F3_SRI);

    always_comb begin
        enc = '0;
        bad = 1'b0;
        case (in_op)
            OP_OP:     enc = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_f3, in_rd, opc};
            OP_LOAD, OP_OPIMM, OP_JALR, OP_MISCMEM, OP_SYSTEM:
                       enc = {shift ? {1'b0, in_alt, 5'b0, in_imm[4:0]} : in_imm[11:0], in_rs1, in_f3, in_rd, opc};
            OP_STORE:  enc = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], opc};
            OP_BRANCH: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3, in_imm[4:1], in_imm[11], opc};
            OP_LUI, OP_AUIPC:
                       enc = {in_imm[31:12], in_rd, opc};
            OP_JAL:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default:   bad = 1'b1;
        endcase
        bad = bad
            | (in_op == OP_BRANCH && in_f3[2:1] == 2'b01)
            | (in_op == OP_LOAD && (in_f3 == 3'b011 || in_f3[2:1] == 2'b11))
            | (in_op == OP_STORE && in_f3 > 3'b010)
            | (in_op == OP_JALR && in_f3 != 3'b000)
            | ((in_op == OP_BRANCH || in_op == OP_JAL) && in_imm[0]);
    end

    // ready depends only on registered occupancy, never on out_ready
    assign in_ready    = !cnt[1];
    assign out_valid   = cnt != 2'd0;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_insn    = out_valid ? mem[head][31:0] : '0;
    assign out_illegal = out_valid && mem[head][32];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem       <= '{default: '0};
            head      <= 1'b0;
            tail      <= 1'b0;
            cnt       <= 2'd0;
            count_ok  <= '0;
            count_bad <= '0;
        end else begin
            if (push) begin
                mem[tail] <= bad ? {1'b1, 32'h0} : {1'b0, enc};
                tail      <= !tail;
                if (!bad && count_ok != '1) count_ok <= count_ok + COUNT_W'(1);
                if (bad && count_bad != '1) count_bad <= count_bad + COUNT_W'(1);
            end
            if (pop) head <= !head;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// tb_rv32i_insn_encoder: scoreboard bench for rv32i_insn_encoder with directed and random requests
module tb_rv32i_insn_encoder;
    logic        clock = 0, rst_n = 1;
    logic        in_valid = 0, sat_valid = 0, out_ready = 0, in_alt = 0;
    logic [4:0]  in_op = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [2:0]  in_f3 = 0;
    logic [31:0] in_imm = 0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_insn;
    logic [15:0] count_ok, count_bad;
    logic        sat_in_ready, sat_out_valid, sat_illegal;
    logic [31:0] sat_insn;
    logic [1:0]  sat_ok, sat_bad;
    int          tests = 0, fails = 0, rdy_mode = 1, m_ok = 0, m_bad = 0, w;
    logic [32:0] q[$];
    logic [4:0]  ops[12] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C, 5'h0B};

    rv32i_insn_encoder #(.COUNT_W(16)) u_dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_f3(in_f3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_illegal(out_illegal), .count_ok(count_ok), .count_bad(count_bad)
    );

    rv32i_insn_encoder #(.COUNT_W(2)) u_sat (
        .clock(clock), .rst_n(rst_n), .in_valid(sat_valid), .in_ready(sat_in_ready),
        .in_op(in_op), .in_f3(in_f3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(sat_out_valid), .out_ready(1'b1),
        .out_insn(sat_insn), .out_illegal(sat_illegal), .count_ok(sat_ok), .count_bad(sat_bad)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: places each field by arithmetic shifts of the format rules
    function automatic logic [32:0] ref_enc(input int unsigned op, f3, alt, rd, rs1, rs2, imm);
        int unsigned x;
        bit ill;
        x = 0;
        ill = 0;
        case (op)
            5'h0C: x = alt << 30 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7;
            5'h00, 5'h03, 5'h04, 5'h19, 5'h1C:
                x = ((op == 4 && (f3 == 1 || f3 == 5)) ? (alt << 30 | (imm & 31) << 20) : (imm & 'hFFF) << 20)
                    | rs1 << 15 | f3 << 12 | rd << 7;
            5'h08: x = ((imm >> 5) & 'h7F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (imm & 31) << 7;
            5'h18: x = ((imm >> 12) & 1) << 31 | ((imm >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15
                       | f3 << 12 | ((imm >> 1) & 15) << 8 | ((imm >> 11) & 1) << 7;
            5'h0D, 5'h05: x = (imm & 'hFFFFF000) | rd << 7;
            5'h1B: x = ((imm >> 20) & 1) << 31 | ((imm >> 1) & 'h3FF) << 21 | ((imm >> 11) & 1) << 20
                       | ((imm >> 12) & 'hFF) << 12 | rd << 7;
            default: ill = 1;
        endcase
        if (op == 5'h18 && (f3 == 2 || f3 == 3)) ill = 1;
        if (op == 5'h00 && (f3 == 3 || f3 >= 6)) ill = 1;
        if (op == 5'h08 && f3 > 2) ill = 1;
        if (op == 5'h19 && f3 != 0) ill = 1;
        if ((op == 5'h18 || op == 5'h1B) && imm % 2 == 1) ill = 1;
        return ill ? {1'b1, 32'h0} : {1'b0, x | (op << 2) | 3};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                        input logic use_exp, input logic [31:0] exp_insn, input logic exp_ill,
                        output int waits);
        logic [32:0] e;
        {in_op, in_f3, in_alt, in_rd, in_rs1, in_rs2, in_imm} = {op, f3, alt, rd, rs1, rs2, imm};
        in_valid = 1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clock);
            @(negedge clock);
            waits++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", waits);
        end else begin
            @(posedge clock);
            e = use_exp ? {exp_ill, exp_insn} : ref_enc(op, f3, alt, rd, rs1, rs2, imm);
            q.push_back(e);
            if (e[32]) m_bad++;
            else m_ok++;
            @(negedge clock);
        end
        in_valid = 0;
    endtask

    always @(negedge clock) begin
        if (rst_n) begin
            chk("count_ok", 32'(count_ok), m_ok);
            chk("count_bad", 32'(count_bad), m_bad);
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", out_insn);
                end else begin
                    chk("out_insn", out_insn, q[0][31:0]);
                    chk("out_illegal", {31'b0, out_illegal}, {31'b0, q[0][32]});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #1 rst_n = 0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_insn", out_insn, 0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_count_ok", 32'(count_ok), 0);
        chk("rst_count_bad", 32'(count_bad), 0);
        repeat (2) @(negedge clock);
        rst_n = 1;
        send(5'h04, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, w);
        send(5'h08, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423, 1'b0, w);
        send(5'h0C, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0, w);
        send(5'h18, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3, 1'b0, w);
        send(5'h0D, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0, w);
        send(5'h1B, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, 1'b0, w);
        send(5'h0B, 3'd2, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0, 1'b1, w);
        send(5'h08, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0, 1'b1, w);
        send(5'h1B, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1, 32'h0, 1'b1, w);
        chk("dir_count_ok", 32'(count_ok), 6);
        chk("dir_count_bad", 32'(count_bad), 3);
        repeat (3) @(negedge clock);
        rdy_mode = 0;
        send(5'h04, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 32'h0, 1'b0, w);
        send(5'h04, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 32'd2, 1'b0, 32'h0, 1'b0, w);
        chk("bp_in_ready_full", {31'b0, in_ready}, 0);
        fork
            send(5'h04, 3'd0, 1'b0, 5'd3, 5'd3, 5'd0, 32'd3, 1'b0, 32'h0, 1'b0, w);
            begin
                repeat (2) @(posedge clock);
                rdy_mode = 1;
            end
        join
        chk("bp_third_wait", w, 3);
        repeat (4) @(negedge clock);
        rdy_mode = 0;
        send(5'h05, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'h0, 1'b0, w);
        send(5'h0C, 3'd7, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h0, 1'b0, w);
        chk("pre_rst_out_valid", {31'b0, out_valid}, 1);
        #2 rst_n = 0;
        q.delete();
        m_ok = 0;
        m_bad = 0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        chk("mid_rst_count_ok", 32'(count_ok), 0);
        chk("mid_rst_count_bad", 32'(count_bad), 0);
        @(negedge clock);
        rst_n = 1;
        rdy_mode = 1;
        {in_op, in_f3, in_rd, in_imm} = {5'h04, 3'd0, 5'd1, 32'd1};
        sat_valid = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("sat_count_2", 32'(sat_ok), 2);
        repeat (3) @(posedge clock);
        @(negedge clock);
        sat_valid = 0;
        chk("sat_count_3", 32'(sat_ok), 3);
        chk("sat_count_bad", 32'(sat_bad), 0);
        rdy_mode = 2;
        repeat (400) begin
            logic [31:0] imm;
            logic [4:0] op;
            int r;
            r = $urandom_range(0, 15);
            op = r < 12 ? ops[r] : 5'($urandom);
            imm = $urandom;
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            send(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 imm, 1'b0, 32'h0, 1'b0, w);
        end
        rdy_mode = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        chk("drain_left", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv32i_insn_encoder.md
Name: rv32i_insn_encoder

Overview:
- Packs RV32I instruction fields (opcode[6:2], funct3, alt bit, rd, rs1, rs2, immediate) into the 32-bit instruction word.
- This is the inverse of the core's instruction decode. It feeds boot/test instruction streams and self-checking stimulus into the fetch path.
- Input and output both use a valid/ready handshake. A 2-entry output FIFO decouples the two sides and keeps ready free of combinational paths.
- Free-running counters report how many legal and illegal requests were encoded.

Parameters:
- COUNT_W, 16, width of the saturating ok/bad request counters.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- in_op  in  5  opcode bits [6:2], using the RV32I OP_* encodings.
- in_f3  in  3  funct3.
- in_alt  in  1  instruction bit 30: SUB/SRA for OP, SRAI for OPIMM shifts.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate as a signed byte offset/value; U-type uses bits [31:12].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_insn  out  32  encoded instruction.
- out_illegal  out  1  head request was unencodable; out_insn is 32'h0 in that case.
- count_ok  out  COUNT_W  legal requests accepted, saturating.
- count_bad  out  COUNT_W  illegal requests accepted, saturating.

Behaviour:
- Reset (async assert, sync deassert by design): FIFO empty; out_valid=0, out_insn=0, out_illegal=0, counts=0, in_ready=1.
- Opcode field is always {in_op, 2'b11}.
- Formats and bit placement:
  - R-type, OP_OP: {1'b0, in_alt, 5'b0, rs2, rs1, f3, rd, opc}.
  - I-type, LOAD/OPIMM/JALR/MISCMEM/SYSTEM: {imm[11:0], rs1, f3, rd, opc}.
  - OPIMM with f3 = F3_SLI or F3_SRI: bits [31:20] = {1'b0, in_alt, 5'b0, imm[4:0]}.
  - S-type, STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}.
  - B-type, BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}.
  - U-type, LUI/AUIPC: {imm[31:12], rd, opc}.
  - J-type, JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}.
- Immediates are truncated silently to their field; there is no range check.
- A request is illegal if any of the following holds:
  - in_op is not in the list above.
  - BRANCH with f3 = 010 or 011.
  - LOAD with f3 = 011, 110 or 111.
  - STORE with f3 > 010.
  - JALR with f3 != 000.
  - BRANCH or JAL with imm[0] = 1.
- An illegal request still enters the FIFO as insn = 0 with illegal = 1. It is never dropped.
- FIFO: 2 entries, encoding is done combinationally at write.
  - in_ready = (occupancy < 2), registered; it never depends on out_ready in the same cycle.
  - Latency: a request accepted at edge N appears at out_valid/out_insn after edge N, i.e. one cycle, when the FIFO was empty.
- Simultaneous push and pop with occupancy 1: occupancy stays 1 and the new entry becomes head next cycle.
- Push and pop with occupancy 2 cannot occur, because in_ready = 0.
- Pop with occupancy 0 is ignored.
- Head and tail pointers wrap modulo 2. Order is strictly FIFO.
- out_insn and out_illegal hold their value while out_valid && !out_ready.
- Counters increment on accept (not on pop) and saturate at all-ones. Exactly one of the two counters increments per accepted request.
- rst_n asserted mid-stream: the FIFO is flushed immediately, in-flight entries are lost, and the counters clear.

Test Plan:
- OPIMM f3=000 rd=1 rs1=0 imm=5 -> out_insn=0x00500093, illegal=0, count_ok=1.
- STORE f3=010 rs1=1 rs2=2 imm=8 -> 0x0020A423; OP f3=000 alt=1 rd=3 rs1=1 rs2=2 -> 0x402081B3.
- BRANCH f3=000 imm=0xFFFFFFFC -> 0xFE000EE3; LUI rd=5 imm=0x12345000 -> 0x123452B7; JAL rd=1 imm=8 -> 0x008000EF.
- Illegal cases: in_op=OP_AMO, STORE f3=011, and JAL imm=3 -> each emits insn=0x0 with illegal=1; count_bad=3, count_ok unchanged.
- Backpressure: out_ready=0, drive 3 back-to-back requests -> in_ready=0 after the second accept, third held. Then out_ready=1 -> outputs emerge in order and the third is accepted the cycle after the first pop.
- Reset mid-stream: FIFO holding 2 entries, pulse rst_n low -> out_valid=0, in_ready=1, counts=0 with no clock edge needed. Also drive COUNT_W=2 with 5 legal requests -> count_ok saturates at 3.
